// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Host-side programmer for the CPU instruction memory external port. It takes
// an image of len words from a valid/ready stream and writes word k to
// BASE_ADDR+4*k. It then reads the image back and compares a modular sum of
// the readback against the sum of the words that were written. If the sums
// match, it raises cpu_enable until halt. If they differ, it parks in ERROR
// and exposes the readback sum.
//
// Ports
//   clk, arst_n        clock (rising edge), asynchronous active-low reset
//   start, len         one-cycle command pulse and image length in words
//   s_valid, s_data    instruction word stream input
//   s_ready            loader can accept a stream word this cycle
//   halt               leave RUN and drop cpu_enable
//   addr_ext, wen_ext, ren_ext, wdata_ext, rdata_ext
//                      instruction memory external port (byte address)
//   cpu_enable         CPU run enable, high only in RUN
//   busy               high while loading or verifying
//   error              high in ERROR
//   err_sum            readback sum captured on a checksum failure
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 32,
    parameter int                CNT_W     = 10,
    parameter int                MAX_WORDS = 512,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              halt,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error,
    output logic [DATA_W-1:0] err_sum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_RUN    = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    len_q,     len_d;
    logic [CNT_W-1:0]    wr_cnt_q,  wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q,  rd_cnt_d;
    logic [DATA_W-1:0]   wsum_q,    wsum_d;
    logic [DATA_W-1:0]   rsum_q,    rsum_d;
    logic [DATA_W-1:0]   err_sum_q, err_sum_d;
    logic                wen_q,     wen_d;
    logic                ren_q,     ren_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic                cpu_en_q,  cpu_en_d;
    // One bit per read in flight. Bit RD_LAT-1 is set in the cycle when
    // rdata_ext carries that read's data.
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:0]     vld_shift;

    logic                len_ok;
    logic                handshake;

    // Byte address of image word k.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] k);
        return BASE_ADDR + ADDR_W'({k, 2'b00});
    endfunction

    assign len_ok    = (len != '0) && (len <= CNT_W'(MAX_WORDS));
    assign s_ready   = (state_q == S_LOAD) && (wr_cnt_q < len_q);
    assign handshake = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wsum_d    = wsum_q;
        err_sum_d = err_sum_q;
        wen_d     = 1'b0;
        ren_d     = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;

        // Accumulate returning read data wherever it lands.
        // Only VERIFY ever issues reads.
        rsum_d     = vld_pipe_q[RD_LAT-1] ? (rsum_q + rdata_ext) : rsum_q;
        vld_shift  = {vld_pipe_q, ren_q};
        vld_pipe_d = vld_shift[RD_LAT-1:0];

        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    wsum_d    = '0;
                    rsum_d    = '0;
                    err_sum_d = '0;
                    if (len_ok) begin
                        state_d = S_LOAD;
                        len_d   = len;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end

            S_LOAD: begin
                if (handshake) begin
                    wen_d    = 1'b1;
                    addr_d   = word_addr(wr_cnt_q);
                    wdata_d  = s_data;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    wsum_d   = wsum_q + s_data;
                end
                // wr_cnt reaches len in the cycle the last write is on the
                // port. VERIFY therefore starts in the following cycle.
                if (wr_cnt_q == len_q) begin
                    state_d = S_VERIFY;
                end
            end

            S_VERIFY: begin
                if (rd_cnt_q < len_q) begin
                    ren_d    = 1'b1;
                    addr_d   = word_addr(rd_cnt_q);
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end else if (!ren_q && (vld_pipe_q == '0)) begin
                    // All reads are issued and their data has been summed.
                    if (rsum_q == wsum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d   = S_ERROR;
                        err_sum_d = rsum_q;
                    end
                end
            end

            S_RUN: begin
                if (halt) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so that cpu_enable rises together with RUN and falls in
        // the cycle after halt.
        cpu_en_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            err_sum_q  <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_en_q   <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            err_sum_q  <= err_sum_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_en_q   <= cpu_en_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign addr_ext   = addr_q;
    assign wen_ext    = wen_q;
    assign ren_ext    = ren_q;
    assign wdata_ext  = wdata_q;
    assign cpu_enable = cpu_en_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign error      = (state_q == S_ERROR);
    assign err_sum    = err_sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader. Two instances share every input: one has RD_LAT=1
// and one has RD_LAT=3. Each instance drives its own memory model. The
// memory model can corrupt bit 0 of word 1 on readback. Expected outcomes
// come from the vector table or from sums over the image queue.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  len_i = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        halt = 1'b0;
    logic        flip_en = 1'b0;

    logic        s_ready1, wen1, ren1, cpu_en1, busy1, err1;
    logic [63:0] addr1;
    logic [31:0] wdata1, rdata1, err_sum1;
    logic        s_ready3, wen3, ren3, cpu_en3, busy3, err3;
    logic [63:0] addr3;
    logic [31:0] wdata3, rdata3, err_sum3;

    always #5 clk = ~clk;

    imem_loader #(.RD_LAT(1)) dut1 (
        .clk(clk), .arst_n(arst_n), .start(start), .len(len_i),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1), .halt(halt),
        .addr_ext(addr1), .wen_ext(wen1), .ren_ext(ren1), .wdata_ext(wdata1),
        .rdata_ext(rdata1), .cpu_enable(cpu_en1), .busy(busy1), .error(err1),
        .err_sum(err_sum1));

    imem_loader #(.RD_LAT(3)) dut3 (
        .clk(clk), .arst_n(arst_n), .start(start), .len(len_i),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready3), .halt(halt),
        .addr_ext(addr3), .wen_ext(wen3), .ren_ext(ren3), .wdata_ext(wdata3),
        .rdata_ext(rdata3), .cpu_enable(cpu_en3), .busy(busy3), .error(err3),
        .err_sum(err_sum3));

    // ---------------- memory models (junk on rdata when not valid) ----------
    function automatic logic [31:0] fmask(input logic [63:0] a);
        return (flip_en && a[11:2] == 10'd1) ? 32'h1 : 32'h0;
    endfunction

    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] rd1_q;
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (wen1) mem1[addr1[11:2]] <= wdata1;
        rd1_q <= ren1 ? (mem1[addr1[11:2]] ^ fmask(addr1)) : $urandom;
        if (wen3) mem3[addr3[11:2]] <= wdata3;
        p3[0] <= ren3 ? (mem3[addr3[11:2]] ^ fmask(addr3)) : $urandom;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata1 = rd1_q;
    assign rdata3 = p3[2];

    // ---------------- port monitor -----------------------------------------
    int          cyc_cnt = 0;
    logic [63:0] wq1_a [$];
    logic [31:0] wq1_d [$];
    int          wq1_c [$];
    int          wq3_n = 0, ren_cnt1 = 0, ren_cnt3 = 0;
    int          rd_idx1 = 0, rd_idx3 = 0, rd_bad = 0, inv_bad = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        #1;
        if (start) begin rd_idx1 = 0; rd_idx3 = 0; end
        if (wen1) begin wq1_a.push_back(addr1); wq1_d.push_back(wdata1); wq1_c.push_back(cyc_cnt); end
        if (wen3) wq3_n++;
        if (ren1) begin if (addr1 != 64'(rd_idx1) * 4) rd_bad++; rd_idx1++; ren_cnt1++; end
        if (ren3) begin if (addr3 != 64'(rd_idx3) * 4) rd_bad++; rd_idx3++; ren_cnt3++; end
        if ((wen1 && ren1) || (cpu_en1 && (wen1 || ren1)) ||
            (wen3 && ren3) || (cpu_en3 && (wen3 || ren3))) inv_bad++;
    end

    // ---------------- checking ---------------------------------------------
    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [31:0] img [$];

    // Entered and left at a negedge. Runs a complete load and checks the
    // write log, the read count and the final state against exp_run/exp_err.
    task automatic do_load(input int n, input bit gap, input bit flip,
                           input bit exp_run, input logic [31:0] exp_err, input string tag);
        int k, cyc, drops, wb1, wb3, rb1, rb3, bad0, bad;
        int hs_cyc [$];
        wb1 = wq1_a.size(); wb3 = wq3_n; rb1 = ren_cnt1; rb3 = ren_cnt3; bad0 = rd_bad;
        flip_en = flip;
        start = 1'b1; len_i = 10'(n);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after start"}, {busy1, busy3}, 2'b11);
        k = 0; cyc = 0; drops = 0;
        while (k < n && cyc < 4 * n + 20) begin
            if (gap && (cyc % 2 == 1)) begin s_valid = 1'b0; s_data = $urandom; end
            else begin s_valid = 1'b1; s_data = img[k]; end
            if (!s_ready1 || (s_ready3 != s_ready1)) drops++;
            if (s_valid && s_ready1) begin hs_cyc.push_back(cyc_cnt); k++; end
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0; s_data = '0;
        check({tag, " handshakes"}, k, n);
        check({tag, " s_ready drops"}, drops, 0);
        check({tag, " s_ready after last"}, {s_ready1, s_ready3}, 2'b00);
        cyc = 0;
        while (!((cpu_en1 || err1) && (cpu_en3 || err3)) && cyc < 4 * n + 60) begin
            @(negedge clk); cyc++;
        end
        #2;
        check({tag, " cpu_enable lat1"}, cpu_en1, exp_run);
        check({tag, " cpu_enable lat3"}, cpu_en3, exp_run);
        check({tag, " error lat1"}, err1, !exp_run);
        check({tag, " error lat3"}, err3, !exp_run);
        check({tag, " err_sum lat1"}, err_sum1, exp_run ? 32'h0 : exp_err);
        check({tag, " err_sum lat3"}, err_sum3, exp_run ? 32'h0 : exp_err);
        check({tag, " busy done"}, {busy1, busy3}, 2'b00);
        check({tag, " write count lat1"}, wq1_a.size() - wb1, n);
        check({tag, " write count lat3"}, wq3_n - wb3, n);
        bad = 0;
        for (int i = 0; i < n && (wb1 + i) < wq1_a.size() && i < hs_cyc.size(); i++) begin
            if (wq1_a[wb1 + i] != 64'(i) * 4) bad++;
            if (wq1_d[wb1 + i] != img[i]) bad++;
            if (wq1_c[wb1 + i] != hs_cyc[i] + 1) bad++;
        end
        check({tag, " write addr/data/timing errors"}, bad, 0);
        check({tag, " read count lat1"}, ren_cnt1 - rb1, n);
        check({tag, " read count lat3"}, ren_cnt3 - rb3, n);
        check({tag, " read addr errors"}, rd_bad - bad0, 0);
        @(negedge clk);
    endtask

    task automatic do_halt(input string tag);
        check({tag, " in RUN before halt"}, {cpu_en1, cpu_en3}, 2'b11);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check({tag, " cpu_enable after halt"}, {cpu_en1, cpu_en3}, 2'b00);
        check({tag, " idle after halt"}, {busy1, err1, s_ready1, busy3, err3, s_ready3}, 6'b0);
    endtask

    typedef struct packed {
        int             n;
        bit             gap;
        bit             flip;
        bit             exp_run;
        logic [31:0]    exp_err;
        logic [3:0][31:0] w;
    } vec_t;

    vec_t tbl [4];

    task automatic load_row(input int r, input string tag);
        img.delete();
        for (int i = 0; i < tbl[r].n; i++) img.push_back(tbl[r].w[i]);
        do_load(tbl[r].n, tbl[r].gap, tbl[r].flip, tbl[r].exp_run, tbl[r].exp_err, tag);
    endtask

    initial begin
        int          k, cyc, wb1, wb3, rb1, rb3, n;
        bit          gap, flip;
        logic [31:0] wsum, rsum;

        tbl[0] = '{4, 1'b0, 1'b0, 1'b1, 32'h0,
                   {32'h00000013, 32'h002081B3, 32'h00A00113, 32'h00500093}};
        tbl[1] = '{3, 1'b1, 1'b0, 1'b1, 32'h0,
                   {32'h0, 32'h00200113, 32'h00100093, 32'h00000013}};
        tbl[2] = '{3, 1'b0, 1'b1, 1'b0, 32'h005000B7,
                   {32'h0, 32'h00000013, 32'h00000010, 32'h00500093}};
        tbl[3] = '{1, 1'b0, 1'b0, 1'b1, 32'h0,
                   {32'h0, 32'h0, 32'h0, 32'h00000013}};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset strobes lat1", {s_ready1, wen1, ren1, cpu_en1, busy1, err1}, 6'b0);
        check("reset strobes lat3", {s_ready3, wen3, ren3, cpu_en3, busy3, err3}, 6'b0);
        check("reset addr/err_sum", {addr1, err_sum1}, '0);
        arst_n = 1'b1;
        @(negedge clk);

        // Back-to-back image of 4 words, then start ignored in RUN, then halt.
        load_row(0, "t1");
        start = 1'b1; len_i = 10'd3;
        @(negedge clk);
        start = 1'b0;
        check("t6 start ignored in RUN", {cpu_en1, cpu_en3, busy1, busy3, s_ready1}, 5'b11000);
        repeat (2) @(negedge clk);
        check("t6 still RUN", {cpu_en1, cpu_en3, busy1, busy3, wen1, ren1}, 6'b110000);
        do_halt("t6");

        // Stream with gaps, then readback corruption.
        load_row(1, "t2");
        do_halt("t2");
        load_row(2, "t3");
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("t3 halt ignored in ERROR", {err1, err3, cpu_en1}, 3'b110);
        check("t3 err_sum held", err_sum1, 32'h005000B7);

        // Illegal lengths.
        #2;
        wb1 = wq1_a.size(); wb3 = wq3_n; rb1 = ren_cnt1; rb3 = ren_cnt3;
        @(negedge clk);
        start = 1'b1; len_i = 10'd0;
        @(negedge clk);
        start = 1'b0;
        check("t4 len0 error", {err1, err3, busy1, busy3}, 4'b1100);
        check("t4 len0 err_sum", {err_sum1, err_sum3}, 64'h0);
        start = 1'b1; len_i = 10'd513;
        @(negedge clk);
        start = 1'b0;
        check("t4 len513 error", {err1, err3, busy1, cpu_en1}, 4'b1100);
        repeat (2) @(negedge clk);
        #2;
        check("t4 no ext strobes",
              (wq1_a.size() - wb1) + (wq3_n - wb3) + (ren_cnt1 - rb1) + (ren_cnt3 - rb3), 0);
        @(negedge clk);
        load_row(3, "t4 len1");
        do_halt("t4");

        // Reset in the middle of a load.
        img.delete();
        for (int i = 0; i < 5; i++) img.push_back($urandom);
        start = 1'b1; len_i = 10'd5;
        @(negedge clk);
        start = 1'b0;
        k = 0; cyc = 0;
        while (k < 2 && cyc < 20) begin
            s_valid = 1'b1; s_data = img[k];
            if (s_ready1) k++;
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("t5 write in flight", wen1, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        check("t5 reset strobes lat1", {s_ready1, wen1, ren1, cpu_en1, busy1, err1}, 6'b0);
        check("t5 reset strobes lat3", {s_ready3, wen3, ren3, cpu_en3, busy3, err3}, 6'b0);
        check("t5 reset addr/wdata", {addr1, wdata1}, '0);
        check("t5 reset err_sum", {err_sum1, err_sum3}, '0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("t5 idle after reset", {s_ready1, s_ready3, busy1, err1, cpu_en1}, 5'b0);
        img.delete();
        img.push_back(32'h00500093);
        img.push_back(32'h00A00113);
        do_load(2, 1'b0, 1'b0, 1'b1, 32'h0, "t5 reload");
        do_halt("t5");

        // Random images against the sum model; the first one is the largest
        // legal length.
        for (int r = 0; r < 6; r++) begin
            n    = (r == 0) ? 512 : int'($urandom_range(1, 16));
            gap  = 1'($urandom_range(0, 1));
            flip = (n >= 2) && ($urandom_range(0, 1) == 1);
            img.delete();
            wsum = '0; rsum = '0;
            for (int i = 0; i < n; i++) begin
                img.push_back($urandom);
                wsum += img[i];
                rsum += (flip && i == 1) ? (img[i] ^ 32'h1) : img[i];
            end
            do_load(n, gap, flip, rsum == wsum, rsum, $sformatf("rnd%0d", r));
            if (cpu_en1 && cpu_en3) do_halt($sformatf("rnd%0d", r));
        end

        check("strobe exclusivity violations", inv_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
